feedback_scorer: RTL and testbench

Downstream feedback stage for the code breaker FSM. On each rising edge of the breaker's LED-process request it latches the maker's and breaker's 12-bit codes and scores the guess over several cycles. Scoring follows Mastermind rules: per-position exact matches, plus right-letter/wrong-position matches. It then drives the result onto the board LEDs for a fixed hold time and pulses `done`.

---
 rtl/feedback_scorer.sv | 179 +++++++++++++++++
 tb/tb_feedback_scorer.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/feedback_scorer.sv
// feedback_scorer: Mastermind scorer for the code breaker. Latches both codes on a start
// edge, scores over 5 cycles, shows the result on LEDs for HOLD_CYCLES, then pulses done.
// Build option FEEDBACK_COUNT_EN: thermometer-coded count LEDs instead of per-position hints.
module feedback_scorer #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] codemaker_code,
    input  logic [11:0] codebreaker_code,
    output logic        busy,
    output logic        done,
    output logic [2:0]  exact_cnt,
    output logic [2:0]  partial_cnt,
    output logic [3:0]  led_exact,
    output logic [3:0]  led_partial
);
    typedef enum logic [2:0] {IDLE, EXACT, PARTIAL, SHOW, DONE} state_t;

    state_t      state_q, state_d;
    logic        start_q;
    logic [11:0] secret_q, secret_d, guess_q, guess_d;
    logic [3:0]  ex_q, ex_d, used_q, used_d, pt_q, pt_d;
    logic [2:0]  exact_q, exact_d, partial_q, partial_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  hold_q, hold_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [3:0]  led_exact_q, led_exact_d, led_partial_q, led_partial_d;

    // Letter arrays and flag vectors share LED bit order: bit 3 is letter 0 (code bits [11:9]).
    logic [2:0]  s_let [4];
    logic [2:0]  g_let [4];
    logic [1:0]  cur;
    logic        hit;
    logic        start_edge;

    assign start_edge = start & ~start_q;
    assign cur        = ~idx_q;

`ifdef FEEDBACK_COUNT_EN
    function automatic logic [3:0] thermo(input logic [2:0] n);
        logic [4:0] t;
        t = (5'd1 << n) - 5'd1;
        return t[3:0];
    endfunction
`endif

    always_comb begin
        for (int unsigned b = 0; b < 4; b++) begin
            s_let[b] = secret_q[3*b +: 3];
            g_let[b] = guess_q[3*b +: 3];
        end
    end

    always_comb begin
        state_d   = state_q;
        secret_d  = secret_q;
        guess_d   = guess_q;
        ex_d      = ex_q;
        used_d    = used_q;
        pt_d      = pt_q;
        exact_d   = exact_q;
        partial_d = partial_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        hit       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    secret_d  = codemaker_code;
                    guess_d   = codebreaker_code;
                    exact_d   = '0;
                    partial_d = '0;
                    ex_d      = '0;
                    used_d    = '0;
                    pt_d      = '0;
                    state_d   = EXACT;
                end
            end
            EXACT: begin
                exact_d = '0;
                for (int unsigned b = 0; b < 4; b++) begin
                    ex_d[b] = (g_let[b] == s_let[b]) && (g_let[b] != 3'd0);
                    exact_d = exact_d + {2'b00, ex_d[b]};
                end
                used_d  = ex_d;
                idx_d   = '0;
                state_d = PARTIAL;
            end
            PARTIAL: begin
                // Walking bits high to low visits secret letters lowest-index first.
                if (!ex_q[cur] && g_let[cur] != 3'd0) begin
                    for (int unsigned k = 4; k > 0; k--) begin
                        if (!hit && !used_q[k-1] && s_let[k-1] == g_let[cur]) begin
                            hit           = 1'b1;
                            used_d[k-1]   = 1'b1;
                        end
                    end
                end
                if (hit) begin
                    pt_d[cur] = 1'b1;
                    partial_d = partial_q + 3'd1;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = SHOW;
                    hold_d  = 8'(HOLD_CYCLES - 1);
                end
            end
            SHOW: begin
                if (hold_q == '0) state_d = DONE;
                else              hold_d  = hold_q - 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        if (state_d == SHOW || state_d == DONE) begin
`ifdef FEEDBACK_COUNT_EN
            led_exact_d   = thermo(exact_d);
            led_partial_d = thermo(partial_d);
`else
            led_exact_d   = ex_d;
            led_partial_d = pt_d;
`endif
        end else begin
            led_exact_d   = '0;
            led_partial_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            start_q       <= 1'b1;
            secret_q      <= '0;
            guess_q       <= '0;
            ex_q          <= '0;
            used_q        <= '0;
            pt_q          <= '0;
            exact_q       <= '0;
            partial_q     <= '0;
            idx_q         <= '0;
            hold_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            led_exact_q   <= '0;
            led_partial_q <= '0;
        end else begin
            state_q       <= state_d;
            start_q       <= start;
            secret_q      <= secret_d;
            guess_q       <= guess_d;
            ex_q          <= ex_d;
            used_q        <= used_d;
            pt_q          <= pt_d;
            exact_q       <= exact_d;
            partial_q     <= partial_d;
            idx_q         <= idx_d;
            hold_q        <= hold_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            led_exact_q   <= led_exact_d;
            led_partial_q <= led_partial_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign exact_cnt   = exact_q;
    assign partial_cnt = partial_q;
    assign led_exact   = led_exact_q;
    assign led_partial = led_partial_q;

endmodule

// File: tb/tb_feedback_scorer.sv
// Self-checking bench for feedback_scorer: directed scenarios plus random codes scored by a
// count-based Mastermind reference model. Honours FEEDBACK_COUNT_EN for the LED encoding.
`timescale 1ns/1ps
module tb_feedback_scorer;
    localparam int unsigned H  = 4;
    localparam int          DK = 6 + int'(H);

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] codemaker_code;
    logic [11:0] codebreaker_code;
    logic        busy;
    logic        done;
    logic [2:0]  exact_cnt;
    logic [2:0]  partial_cnt;
    logic [3:0]  led_exact;
    logic [3:0]  led_partial;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0] o_exact2, o_partial6;
    logic [3:0] o_le, o_lp;
    int         o_done_k, o_ndone;
    bit         o_led_bad, o_busy_bad, o_hold_bad;

    feedback_scorer #(.HOLD_CYCLES(H)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .codemaker_code   (codemaker_code),
        .codebreaker_code (codebreaker_code),
        .busy             (busy),
        .done             (done),
        .exact_cnt        (exact_cnt),
        .partial_cnt      (partial_cnt),
        .led_exact        (led_exact),
        .led_partial      (led_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, failures so far %0d", n_fail);
        $fatal(1);
    end

    // Counts from colour histograms; per-position flags from a lowest-index greedy pass.
    function automatic void model(input logic [11:0] s, input logic [11:0] g,
                                  output logic [2:0] ex_n, output logic [2:0] pa_n,
                                  output logic [3:0] le, output logic [3:0] lp);
        int sl[4];
        int gl[4];
        int cs[8];
        int cg[8];
        bit used[4];
        bit hit;
        logic [3:0] exf, ptf;
        int e, m;
        e = 0; m = 0; exf = '0; ptf = '0;
        for (int c = 0; c < 8; c++) begin cs[c] = 0; cg[c] = 0; end
        for (int i = 0; i < 4; i++) begin
            sl[i] = int'(s[11-3*i -: 3]);
            gl[i] = int'(g[11-3*i -: 3]);
            cs[sl[i]]++;
            cg[gl[i]]++;
            used[i] = (gl[i] == sl[i]) && (gl[i] != 0);
            if (used[i]) begin e++; exf[3-i] = 1'b1; end
        end
        for (int c = 1; c < 8; c++) m += (cs[c] < cg[c]) ? cs[c] : cg[c];
        for (int i = 0; i < 4; i++) begin
            if (!exf[3-i] && gl[i] != 0) begin
                hit = 0;
                for (int j = 0; j < 4; j++) begin
                    if (!hit && !used[j] && sl[j] == gl[i]) begin
                        hit = 1; used[j] = 1; ptf[3-i] = 1'b1;
                    end
                end
            end
        end
        ex_n = 3'(e);
        pa_n = 3'(m - e);
`ifdef FEEDBACK_COUNT_EN
        le = 4'((1 << e) - 1);
        lp = 4'((1 << (m - e)) - 1);
`else
        le = exf;
        lp = ptf;
`endif
    endfunction

    function automatic logic [11:0] rand_code(input bit wide);
        logic [11:0] c;
        for (int i = 0; i < 4; i++) c[3*i +: 3] = 3'($urandom_range(0, wide ? 7 : 3));
        return c;
    endfunction

    // Launches one scoring run and records what the outputs did, cycle k = t+k.
    task automatic do_run(input logic [11:0] s, input logic [11:0] g,
                          input int chg_k, input logic [11:0] alt);
        @(negedge clk);
        codemaker_code = s; codebreaker_code = g; start = 1'b1;
        o_done_k = 0; o_ndone = 0; o_led_bad = 0; o_busy_bad = 0; o_hold_bad = 0;
        o_exact2 = 'x; o_partial6 = 'x; o_le = 'x; o_lp = 'x;
        for (int k = 1; k <= DK + 2; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == chg_k) begin codebreaker_code = alt; codemaker_code = ~alt; end
            if (k == 2) o_exact2 = exact_cnt;
            if (k == 6) begin o_partial6 = partial_cnt; o_le = led_exact; o_lp = led_partial; end
            if (k >= 2 && exact_cnt !== o_exact2) o_hold_bad = 1;
            if (k >= 6 && partial_cnt !== o_partial6) o_hold_bad = 1;
            if (k < 6 || k > DK) begin
                if (led_exact !== 4'd0 || led_partial !== 4'd0) o_led_bad = 1;
            end else if (led_exact !== o_le || led_partial !== o_lp) o_led_bad = 1;
            if (busy !== (k <= DK)) o_busy_bad = 1;
            if (done === 1'b1) begin
                o_ndone++;
                if (o_done_k == 0) o_done_k = k;
            end
        end
    endtask

    task automatic test_reset;
        bit bad;
        reset = 1'b0; start = 1'b1;
        codemaker_code = 12'o1234; codebreaker_code = 12'o1234;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, exact_cnt, partial_cnt, led_exact, led_partial} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {busy, done, exact_cnt, partial_cnt, led_exact, led_partial});
        end
        reset = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0) bad = 1;
        end
        n_checks++;
        if (bad) begin n_fail++; $display("FAIL reset_start_held: busy got 1 expected 0"); end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_match;
        do_run({3'd1, 3'd2, 3'd3, 3'd4}, {3'd1, 3'd2, 3'd3, 3'd4}, 0, 12'd0);
        n_checks++;
        if (o_exact2 !== 3'd4) begin n_fail++; $display("FAIL full_exact: got %0d expected 4", o_exact2); end
        n_checks++;
        if (o_partial6 !== 3'd0) begin n_fail++; $display("FAIL full_partial: got %0d expected 0", o_partial6); end
        n_checks++;
        if (o_le !== 4'b1111 || o_lp !== 4'b0000) begin
            n_fail++; $display("FAIL full_leds: got %b/%b expected 1111/0000", o_le, o_lp);
        end
        n_checks++;
        if (o_done_k !== DK || o_ndone !== 1) begin
            n_fail++; $display("FAIL full_done: got cycle %0d count %0d expected cycle %0d count 1", o_done_k, o_ndone, DK);
        end
        n_checks++;
        if (o_busy_bad || o_led_bad || o_hold_bad) begin
            n_fail++; $display("FAIL full_timing: busy_bad=%0d led_bad=%0d hold_bad=%0d expected 0/0/0", o_busy_bad, o_led_bad, o_hold_bad);
        end
    endtask

    task automatic test_duplicates;
        logic [3:0] xe, xp;
`ifdef FEEDBACK_COUNT_EN
        xe = 4'b0001; xp = 4'b0011;
`else
        xe = 4'b0100; xp = 4'b1010;
`endif
        do_run({3'd1, 3'd1, 3'd2, 3'd3}, {3'd3, 3'd1, 3'd1, 3'd1}, 0, 12'd0);
        n_checks++;
        if (o_exact2 !== 3'd1 || o_partial6 !== 3'd2) begin
            n_fail++; $display("FAIL dup_counts: got %0d/%0d expected 1/2", o_exact2, o_partial6);
        end
        n_checks++;
        if (o_le !== xe || o_lp !== xp) begin
            n_fail++; $display("FAIL dup_leds: got %b/%b expected %b/%b", o_le, o_lp, xe, xp);
        end
    endtask

    task automatic test_no_match;
        do_run({3'd5, 3'd5, 3'd6, 3'd6}, {3'd0, 3'd7, 3'd0, 3'd7}, 0, 12'd0);
        n_checks++;
        if (o_exact2 !== 3'd0 || o_partial6 !== 3'd0) begin
            n_fail++; $display("FAIL nomatch_counts: got %0d/%0d expected 0/0", o_exact2, o_partial6);
        end
        n_checks++;
        if (o_le !== 4'd0 || o_lp !== 4'd0 || o_led_bad) begin
            n_fail++; $display("FAIL nomatch_leds: got %b/%b led_bad=%0d expected 0000/0000 0", o_le, o_lp, o_led_bad);
        end
        n_checks++;
        if (o_done_k !== DK || o_ndone !== 1) begin
            n_fail++; $display("FAIL nomatch_done: got cycle %0d count %0d expected %0d/1", o_done_k, o_ndone, DK);
        end
    endtask

    task automatic test_start_held;
        int nd, k1, k2;
        logic b11, b12;
        logic [2:0] xe, xp;
        logic [3:0] le, lp;
        nd = 0; k1 = 0; k2 = 0; b11 = 1'bx; b12 = 1'bx;
        @(negedge clk);
        codemaker_code = {3'd2, 3'd4, 3'd4, 3'd1}; codebreaker_code = {3'd4, 3'd4, 3'd2, 3'd7};
        start = 1'b1;
        for (int k = 1; k <= 2 * DK + 4; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                nd++;
                if (k1 == 0) k1 = k; else if (k2 == 0) k2 = k;
            end
            if (k == DK + 1) b11 = busy;
            if (k == DK + 2) b12 = busy;
            if (k == 6)      start = 1'b0;
            if (k == 7)      start = 1'b1;
            if (k == 8)      start = 1'b0;
            if (k == DK + 1) start = 1'b1;
            if (k == DK + 2) start = 1'b0;
        end
        n_checks++;
        if (nd !== 2 || k1 !== DK || k2 !== 2 * DK + 1) begin
            n_fail++; $display("FAIL held_done: got count %0d at %0d,%0d expected 2 at %0d,%0d", nd, k1, k2, DK, 2 * DK + 1);
        end
        n_checks++;
        if (b11 !== 1'b0 || b12 !== 1'b1) begin
            n_fail++; $display("FAIL held_rearm_busy: got %b%b expected 01", b11, b12);
        end
        model({3'd2, 3'd4, 3'd4, 3'd1}, {3'd4, 3'd4, 3'd2, 3'd7}, xe, xp, le, lp);
        n_checks++;
        if (exact_cnt !== xe || partial_cnt !== xp) begin
            n_fail++; $display("FAIL held_counts: got %0d/%0d expected %0d/%0d", exact_cnt, partial_cnt, xe, xp);
        end
    endtask

    task automatic test_done_edge;
        int nd;
        bit bad;
        nd = 0; bad = 0;
        @(negedge clk);
        codemaker_code = 12'o1234; codebreaker_code = 12'o4321; start = 1'b1;
        for (int k = 1; k <= DK + 5; k++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
            if (k > DK && busy !== 1'b0) bad = 1;
            if (k == 1)      start = 1'b0;
            if (k == DK)     start = 1'b1;
            if (k == DK + 1) start = 1'b0;
        end
        n_checks++;
        if (nd !== 1 || bad) begin
            n_fail++; $display("FAIL done_cycle_edge: got done count %0d busy_after=%0d expected 1/0", nd, bad);
        end
    endtask

    task automatic test_reset_mid_run;
        logic [2:0] pre;
        int nd;
        logic [2:0] xe, xp;
        logic [3:0] le, lp;
        logic [11:0] s, g;
        @(negedge clk);
        codemaker_code = {3'd1, 3'd2, 3'd3, 3'd4}; codebreaker_code = {3'd1, 3'd2, 3'd6, 3'd5};
        start = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        pre = exact_cnt;
        reset = 1'b0;
        #1;
        n_checks++;
        if (pre !== 3'd2) begin n_fail++; $display("FAIL midrst_pre_exact: got %0d expected 2", pre); end
        n_checks++;
        if ({busy, done, exact_cnt, partial_cnt, led_exact, led_partial} !== 16'd0) begin
            n_fail++; $display("FAIL midrst_outputs: got %h expected 0000",
                               {busy, done, exact_cnt, partial_cnt, led_exact, led_partial});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        nd = 0;
        repeat (DK + 4) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        n_checks++;
        if (nd !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d active cycles expected 0", nd); end
        s = rand_code(0); g = rand_code(0);
        model(s, g, xe, xp, le, lp);
        do_run(s, g, 0, 12'd0);
        n_checks++;
        if (o_exact2 !== xe || o_partial6 !== xp || o_le !== le || o_lp !== lp || o_done_k !== DK) begin
            n_fail++; $display("FAIL midrst_rerun: got %0d/%0d %b/%b done@%0d expected %0d/%0d %b/%b done@%0d",
                               o_exact2, o_partial6, o_le, o_lp, o_done_k, xe, xp, le, lp, DK);
        end
    endtask

    task automatic test_late_change;
        logic [2:0] xe, xp;
        logic [3:0] le, lp;
        model({3'd1, 3'd2, 3'd3, 3'd4}, {3'd4, 3'd3, 3'd2, 3'd1}, xe, xp, le, lp);
        do_run({3'd1, 3'd2, 3'd3, 3'd4}, {3'd4, 3'd3, 3'd2, 3'd1}, 3, {3'd1, 3'd2, 3'd3, 3'd4});
        n_checks++;
        if (o_exact2 !== xe || o_partial6 !== xp || o_le !== le || o_lp !== lp) begin
            n_fail++; $display("FAIL late_change: got %0d/%0d %b/%b expected %0d/%0d %b/%b",
                               o_exact2, o_partial6, o_le, o_lp, xe, xp, le, lp);
        end
    endtask

    task automatic test_random;
        logic [11:0] s, g;
        logic [2:0] xe, xp;
        logic [3:0] le, lp;
        for (int it = 0; it < 40; it++) begin
            s = rand_code(it[0]);
            g = rand_code(it[0]);
            if (it % 7 == 0) g = s;
            model(s, g, xe, xp, le, lp);
            do_run(s, g, 0, 12'd0);
            n_checks++;
            if (o_exact2 !== xe || o_partial6 !== xp) begin
                n_fail++; $display("FAIL rand_counts[%0d] s=%o g=%o: got %0d/%0d expected %0d/%0d", it, s, g, o_exact2, o_partial6, xe, xp);
            end
            n_checks++;
            if (o_le !== le || o_lp !== lp) begin
                n_fail++; $display("FAIL rand_leds[%0d] s=%o g=%o: got %b/%b expected %b/%b", it, s, g, o_le, o_lp, le, lp);
            end
            n_checks++;
            if (o_done_k !== DK || o_ndone !== 1 || o_busy_bad || o_led_bad || o_hold_bad) begin
                n_fail++; $display("FAIL rand_timing[%0d]: got done@%0d x%0d flags %0d%0d%0d expected done@%0d x1 flags 000",
                                   it, o_done_k, o_ndone, o_busy_bad, o_led_bad, o_hold_bad, DK);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_match();
        test_duplicates();
        test_no_match();
        test_start_held();
        test_done_edge();
        test_reset_mid_run();
        test_late_change();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
